ws2812_matrix_stream: RTL

- Next-generation WS2812 matrix driver, generalised to any WIDTH x HEIGHT panel.
- Takes a 1bpp frame, a 24-bit RGB foreground colour and a 24-bit background colour. Serialises GRB pixel data directly from the latched frame; no per-LED 24-bit shadow buffer.
- Sits between the frame/animation logic and the panel data pin.
- Adds a valid/ready frame handshake, selectable serpentine wiring, a background colour and a frame-done pulse.

---
 rtl/ws2812_matrix_stream.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/ws2812_matrix_stream.sv
// WS2812 matrix driver: streams a latched 1bpp WIDTH x HEIGHT frame as GRB pixels.
// Define WS2812_BRIGHTNESS_EN to scale every channel by (brightness+1)/256 at accept.
module ws2812_matrix_stream #(
  parameter int unsigned CLK_FREQ   = 20000000,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned HEIGHT     = 16,
  parameter int unsigned SERPENTINE = 1,
  parameter int unsigned T0H_NS     = 400,
  parameter int unsigned T1H_NS     = 800,
  parameter int unsigned BIT_NS     = 1250,
  parameter int unsigned LATCH_US   = 200
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [WIDTH*HEIGHT-1:0] frame,
  input  logic [23:0]             fg_rgb,
  input  logic [23:0]             bg_rgb,
  input  logic [7:0]              brightness,
  input  logic                    frame_valid,
  output logic                    frame_ready,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    o_out
);

  localparam int unsigned N = WIDTH * HEIGHT;

  localparam longint unsigned T0H_L =
    (64'(CLK_FREQ) * 64'(T0H_NS)) / 64'd1000000000;
  localparam longint unsigned T1H_L =
    (64'(CLK_FREQ) * 64'(T1H_NS)) / 64'd1000000000;
  localparam longint unsigned BIT_L =
    (64'(CLK_FREQ) * 64'(BIT_NS)) / 64'd1000000000;
  localparam longint unsigned LAT_L =
    (64'(CLK_FREQ) * 64'(LATCH_US)) / 64'd1000000;

  localparam int unsigned T0H_C   = 32'(T0H_L);
  localparam int unsigned T1H_C   = 32'(T1H_L);
  localparam int unsigned BIT_C   = 32'(BIT_L);
  localparam int unsigned LATCH_C = 32'(LAT_L);

  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BW = $clog2(24);
  localparam int YW = (BIT_C > 1) ? $clog2(BIT_C) : 1;
  localparam int TW = (LATCH_C > 0) ? $clog2(LATCH_C + 1) : 1;

  if ((T1H_C >= BIT_C) || (T0H_C == 0)) begin : g_bad_timing
    $error("ws2812_matrix_stream: T1H_C must be < BIT_C and T0H_C > 0");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_LATCH
  } state_t;

  state_t          r_state;
  logic [YW-1:0]   r_cyc;
  logic [BW-1:0]   r_bit;
  logic [LW-1:0]   r_led;
  logic [CW-1:0]   r_col;
  logic            r_odd;
  logic [LW-1:0]   r_base;
  logic [TW-1:0]   r_lcnt;
  logic            r_out;
  logic            r_done;

  logic [N-1:0]    r_frame;
  logic [23:0]     r_fg;
  logic [23:0]     r_bg;

  state_t          w_state_n;
  logic [YW-1:0]   w_cyc_n;
  logic [BW-1:0]   w_bit_n;
  logic [LW-1:0]   w_led_n;
  logic [CW-1:0]   w_col_n;
  logic            w_odd_n;
  logic [LW-1:0]   w_base_n;
  logic [TW-1:0]   w_lcnt_n;
  logic            w_done_n;
  logic            w_accept;

  logic [23:0]     w_fg_in;
  logic [23:0]     w_bg_in;
  logic [CW-1:0]   w_col_eff;
  logic [LW-1:0]   w_idx;
  logic            w_lit;
  logic [23:0]     w_rgb;
  logic [23:0]     w_grb;
  logic            w_bitv;
  logic            w_out_n;

`ifdef WS2812_BRIGHTNESS_EN
  function automatic logic [7:0] f_scale(
    input logic [7:0] ch,
    input logic [7:0] br
  );
    logic [15:0] p;
    p = ({8'd0, ch} * {8'd0, br}) + {8'd0, ch};
    return 8'(p >> 8);
  endfunction

  assign w_fg_in = {f_scale(fg_rgb[23:16], brightness),
                    f_scale(fg_rgb[15:8], brightness),
                    f_scale(fg_rgb[7:0], brightness)};
  assign w_bg_in = {f_scale(bg_rgb[23:16], brightness),
                    f_scale(bg_rgb[15:8], brightness),
                    f_scale(bg_rgb[7:0], brightness)};
`else
  logic w_unused_brightness;
  assign w_unused_brightness = ^brightness;
  assign w_fg_in = fg_rgb;
  assign w_bg_in = bg_rgb;
`endif

  assign w_accept = (r_state == S_IDLE) && frame_valid;

  always_comb begin
    w_state_n = r_state;
    w_cyc_n   = r_cyc;
    w_bit_n   = r_bit;
    w_led_n   = r_led;
    w_col_n   = r_col;
    w_odd_n   = r_odd;
    w_base_n  = r_base;
    w_lcnt_n  = r_lcnt;
    w_done_n  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (frame_valid) begin
          w_state_n = S_SEND;
          w_cyc_n   = '0;
          w_bit_n   = '0;
          w_led_n   = '0;
          w_col_n   = '0;
          w_odd_n   = 1'b0;
          w_base_n  = '0;
        end
      end
      S_SEND: begin
        if (r_cyc == YW'(BIT_C - 1)) begin
          w_cyc_n = '0;
          if (r_bit == BW'(23)) begin
            w_bit_n = '0;
            if (r_led == LW'(N - 1)) begin
              w_state_n = S_LATCH;
              w_lcnt_n  = TW'(LATCH_C);
            end else begin
              w_led_n = r_led + LW'(1);
              if (r_col == CW'(WIDTH - 1)) begin
                w_col_n  = '0;
                w_odd_n  = ~r_odd;
                w_base_n = r_base + LW'(WIDTH);
              end else begin
                w_col_n = r_col + CW'(1);
              end
            end
          end else begin
            w_bit_n = r_bit + BW'(1);
          end
        end else begin
          w_cyc_n = r_cyc + YW'(1);
        end
      end
      S_LATCH: begin
        if (r_lcnt <= TW'(1)) begin
          w_state_n = S_IDLE;
          w_lcnt_n  = '0;
          w_done_n  = 1'b1;
        end else begin
          w_lcnt_n = r_lcnt - TW'(1);
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Look up the bit that will be on the wire next cycle, so o_out stays registered.
  assign w_col_eff = ((SERPENTINE != 0) && w_odd_n)
                   ? (CW'(WIDTH - 1) - w_col_n) : w_col_n;
  assign w_idx   = w_base_n + LW'(w_col_eff);
  assign w_lit   = r_frame[w_idx];
  assign w_rgb   = w_lit ? r_fg : r_bg;
  assign w_grb   = {w_rgb[15:8], w_rgb[23:16], w_rgb[7:0]};
  assign w_bitv  = w_grb[BW'(23) - w_bit_n];
  assign w_out_n = (w_state_n == S_SEND) &&
                   (w_cyc_n < (w_bitv ? YW'(T1H_C) : YW'(T0H_C)));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_led   <= '0;
      r_col   <= '0;
      r_odd   <= 1'b0;
      r_base  <= '0;
      r_lcnt  <= '0;
      r_out   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cyc   <= w_cyc_n;
      r_bit   <= w_bit_n;
      r_led   <= w_led_n;
      r_col   <= w_col_n;
      r_odd   <= w_odd_n;
      r_base  <= w_base_n;
      r_lcnt  <= w_lcnt_n;
      r_out   <= w_out_n;
      r_done  <= w_done_n;
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_frame <= frame;
      r_fg    <= w_fg_in;
      r_bg    <= w_bg_in;
    end
  end

  assign frame_ready = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign frame_done  = r_done;
  assign o_out       = r_out;

endmodule
